// File: rtl/matcher_result_collector_pkg.sv
// -----------------------------------------------------------------------------
// matcher_result_collector_pkg
//   Shared definitions for the matcher result collector:
//   - state_e          : collector FSM state encoding
//   - offset_width()   : byte-offset width for a given stream width
//   - record_width()   : width of one {offset, data} output record
//   - lowest_set_bit() : combinational priority search (lowest index wins)
// -----------------------------------------------------------------------------
package matcher_result_collector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SCAN     = 3'd2,
    ST_ACK      = 3'd3,
    ST_ACK_WAIT = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

  // Widest bitmap the search function handles (stream widths up to 8192 bits).
  localparam int MAX_BITMAP_W = 1024;

  function automatic int offset_width(input int stream_width);
    return $clog2(stream_width / 8);
  endfunction

  function automatic int record_width(input int stream_width, input int data_width);
    return offset_width(stream_width) + data_width;
  endfunction

  // Scans from the top down so the last hit written is the lowest set index.
  // Returns 0 for an all-zero bitmap; callers qualify with a nonzero test.
  function automatic int unsigned lowest_set_bit(input logic [MAX_BITMAP_W-1:0] bitmap);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_BITMAP_W - 1; i >= 0; i--) begin
      if (bitmap[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/matcher_result_collector_if.sv
// -----------------------------------------------------------------------------
// matcher_result_collector_if
//   Bundles the filter-stage handshake and the match record stream.
//   modport master : the collector (consumes filter results, sources records)
//   modport slave  : the environment (filter stage + record consumer)
//   Signals:
//     filter_result        bitmap, one bit per byte offset
//     filter_result_data   filter-list entry that produced the bitmap
//     filter_result_valid  level, bitmap/data stable while high
//     filter_result_done   level, filter list exhausted
//     filter_result_reset  one-cycle pulse, result consumed
//     match_valid/ready    record handshake
//     match_offset/data    record payload
//     match_count          records pushed this session (saturating)
//     session_done         filter finished and records drained
// -----------------------------------------------------------------------------
interface matcher_result_collector_if
  import matcher_result_collector_pkg::*;
#(
  parameter int INPUT_STREAM_WIDTH = 512,
  parameter int DATA_WIDTH         = 24,
  parameter int COUNT_WIDTH        = 16
);
  localparam int BITMAP_W = INPUT_STREAM_WIDTH / 8;
  localparam int OFFSET_W = offset_width(INPUT_STREAM_WIDTH);

  logic [BITMAP_W-1:0]    filter_result;
  logic [DATA_WIDTH-1:0]  filter_result_data;
  logic                   filter_result_valid;
  logic                   filter_result_done;
  logic                   filter_result_reset;
  logic                   match_valid;
  logic                   match_ready;
  logic [OFFSET_W-1:0]    match_offset;
  logic [DATA_WIDTH-1:0]  match_data;
  logic [COUNT_WIDTH-1:0] match_count;
  logic                   session_done;

  modport master (
    input  filter_result, filter_result_data, filter_result_valid,
           filter_result_done, match_ready,
    output filter_result_reset, match_valid, match_offset, match_data,
           match_count, session_done
  );

  modport slave (
    output filter_result, filter_result_data, filter_result_valid,
           filter_result_done, match_ready,
    input  filter_result_reset, match_valid, match_offset, match_data,
           match_count, session_done
  );

endinterface

// File: rtl/matcher_result_collector_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with first-word-fall-through output.
//   Ports:
//     clk, rst_n         clock, synchronous active-low reset
//     i_push/i_push_data write request and data
//     o_full             no free entry (a push still lands if a pop coincides)
//     i_pop              read request; ignored while empty
//     o_pop_data         head entry, forced to zero while empty
//     o_empty            no stored entry
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_push_en;
  logic             w_pop_en;

  // Pointers carry one wrap bit: equal -> empty, equal except wrap bit -> full.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_pop_en  = i_pop && !o_empty;
  // When full, the slot being written is the one being read out this cycle.
  assign w_push_en = i_push && (!o_full || w_pop_en);

  // NOTE: storage has no reset; the empty flag masks stale contents, which
  // lets the array map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
    end
  end

  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/matcher_result_collector.sv
// -----------------------------------------------------------------------------
// matcher_result_collector
//   Takes per-byte match bitmaps from the filter stage, serialises every set
//   bit into an {offset, data} record (lowest offset first), queues records in
//   a sync_fifo and hands the filter a one-cycle "consumed" pulse per bitmap.
//   Ports:
//     fclk      clock, all logic on its rising edge
//     areset_n  synchronous active-low reset
//     bus       matcher_result_collector_if.master (filter side + record side)
// -----------------------------------------------------------------------------
module matcher_result_collector
  import matcher_result_collector_pkg::*;
#(
  parameter int INPUT_STREAM_WIDTH = 512,
  parameter int DATA_WIDTH         = 24,
  parameter int FIFO_DEPTH         = 8,
  parameter int COUNT_WIDTH        = 16
) (
  input logic                        fclk,
  input logic                        areset_n,
  matcher_result_collector_if.master bus
);
  localparam int BITMAP_W = INPUT_STREAM_WIDTH / 8;
  localparam int OFFSET_W = offset_width(INPUT_STREAM_WIDTH);
  localparam int REC_W    = record_width(INPUT_STREAM_WIDTH, DATA_WIDTH);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [BITMAP_W-1:0]    r_bitmap;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [COUNT_WIDTH-1:0] r_match_count;

  logic                   w_bitmap_zero;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_pop;
  logic                   w_can_push;
  logic                   w_load;
  logic                   w_push;
  logic                   w_count_clear;
  logic                   w_filter_reset;
  logic [OFFSET_W-1:0]    w_offset;
  logic [REC_W-1:0]       w_push_rec;
  logic [REC_W-1:0]       w_pop_rec;

  assign w_bitmap_zero = (r_bitmap == '0);
  assign w_offset      = OFFSET_W'(lowest_set_bit(MAX_BITMAP_W'(r_bitmap)));
  assign w_push_rec    = {w_offset, r_data};
  assign w_pop         = bus.match_valid && bus.match_ready;
  // A full FIFO still accepts a record when its head leaves in the same cycle.
  assign w_can_push    = !w_fifo_full || w_pop;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge fclk) begin
    if (!areset_n) r_state <= ST_IDLE;
    else           r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_push         = 1'b0;
    w_count_clear  = 1'b0;
    w_filter_reset = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.filter_result_valid)     w_state_next = ST_LOAD;
        else if (bus.filter_result_done) w_state_next = ST_FINISH;
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_bitmap_zero)   w_state_next = ST_ACK;
        else if (w_can_push) w_push       = 1'b1;
      end
      ST_ACK: begin
        w_filter_reset = 1'b1;
        w_state_next   = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        // The filter must withdraw the consumed result before a new one is taken.
        if (!bus.filter_result_valid) w_state_next = ST_IDLE;
      end
      ST_FINISH: begin
        if (!bus.filter_result_done) begin
          w_count_clear = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Working bitmap / data register
  // ---------------------------------------------------------------------------
  always_ff @(posedge fclk) begin
    if (!areset_n) begin
      r_bitmap <= '0;
      r_data   <= '0;
    end else if (w_load) begin
      r_bitmap <= bus.filter_result;
      r_data   <= bus.filter_result_data;
    end else if (w_push) begin
      r_bitmap[w_offset] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating match counter, cleared when a session is closed
  // ---------------------------------------------------------------------------
  always_ff @(posedge fclk) begin
    if (!areset_n) begin
      r_match_count <= '0;
    end else if (w_count_clear) begin
      r_match_count <= '0;
    end else if (w_push && (r_match_count != '1)) begin
      r_match_count <= r_match_count + COUNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Record buffer
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (fclk),
    .rst_n       (areset_n),
    .i_push      (w_push),
    .i_push_data (w_push_rec),
    .o_full      (w_fifo_full),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_rec),
    .o_empty     (w_fifo_empty)
  );

  assign bus.match_valid         = !w_fifo_empty;
  assign bus.match_offset        = w_pop_rec[REC_W-1 -: OFFSET_W];
  assign bus.match_data          = w_pop_rec[DATA_WIDTH-1:0];
  assign bus.match_count         = r_match_count;
  assign bus.filter_result_reset = w_filter_reset;
  assign bus.session_done        = (r_state == ST_FINISH) && w_fifo_empty;

endmodule

// File: tb/tb_matcher_result_collector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_matcher_result_collector
//   Directed scenarios with hand-computed expectations. A second instance with
//   a 2-bit counter exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_matcher_result_collector;
  localparam int ISW    = 512;
  localparam int DW     = 24;
  localparam int FD     = 8;
  localparam int CW     = 16;
  localparam int SAT_CW = 2;

  typedef struct {
    logic [5:0]  off;
    logic [23:0] data;
  } rec_t;

  logic fclk;
  logic areset_n;
  int   errors = 0;
  int   checks = 0;
  rec_t got_q[$];
  int   pulses  = 0;
  int   recs2   = 0;
  int   pulses2 = 0;

  matcher_result_collector_if #(.INPUT_STREAM_WIDTH(ISW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW))     bus ();
  matcher_result_collector_if #(.INPUT_STREAM_WIDTH(ISW), .DATA_WIDTH(DW), .COUNT_WIDTH(SAT_CW)) bus2 ();

  matcher_result_collector #(
    .INPUT_STREAM_WIDTH(ISW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW)
  ) dut (
    .fclk(fclk), .areset_n(areset_n), .bus(bus)
  );

  matcher_result_collector #(
    .INPUT_STREAM_WIDTH(ISW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .COUNT_WIDTH(SAT_CW)
  ) dut_sat (
    .fclk(fclk), .areset_n(areset_n), .bus(bus2)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // Handshakes are observed mid-cycle, where inputs and outputs are settled
  // for the coming rising edge.
  always @(negedge fclk) begin
    if (areset_n && bus.match_valid && bus.match_ready)
      got_q.push_back('{off: bus.match_offset, data: bus.match_data});
    if (bus.filter_result_reset) pulses++;
    if (areset_n && bus2.match_valid && bus2.match_ready) recs2++;
    if (bus2.filter_result_reset) pulses2++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic apply_reset();
    areset_n                 = 1'b0;
    bus.filter_result        = '0;
    bus.filter_result_data   = '0;
    bus.filter_result_valid  = 1'b0;
    bus.filter_result_done   = 1'b0;
    bus.match_ready          = 1'b1;
    step();
    step();
    areset_n = 1'b1;
  endtask

  task automatic wait_pulse(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (bus.filter_result_reset) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_pulse_timeout: filter_result_reset not seen, need one within 60 cycles", name);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    areset_n                = 1'b0;
    bus.filter_result       = 64'hFF;
    bus.filter_result_data  = 24'h123456;
    bus.filter_result_valid = 1'b1;
    bus.filter_result_done  = 1'b1;
    bus.match_ready         = 1'b1;
    step();
    step();
    checks++; if (bus.match_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", bus.match_valid); end
    checks++; if (bus.match_offset !== 6'd0) begin errors++; $display("FAIL reset_offset: got %0d need 0", bus.match_offset); end
    checks++; if (bus.match_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h need 000000", bus.match_data); end
    checks++; if (bus.match_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h need 0000", bus.match_count); end
    checks++; if (bus.session_done !== 1'b0) begin errors++; $display("FAIL reset_session_done: got %b need 0", bus.session_done); end
    checks++; if (bus.filter_result_reset !== 1'b0) begin errors++; $display("FAIL reset_filter_reset: got %b need 0", bus.filter_result_reset); end
    bus.filter_result_valid = 1'b0;
    bus.filter_result_done  = 1'b0;
    areset_n = 1'b1;
    step();
  endtask

  // Bits 0,2,8 with data 0xABCDEF; also checks one-cycle push-to-output latency.
  task automatic test_basic();
    int base, p0;
    logic [5:0] exp_off [3];
    exp_off = '{6'd0, 6'd2, 6'd8};
    apply_reset();
    base = got_q.size();
    p0   = pulses;
    bus.filter_result       = 64'h105;
    bus.filter_result_data  = 24'hABCDEF;
    bus.filter_result_valid = 1'b1;
    step();  // IDLE -> LOAD
    step();  // LOAD -> SCAN
    checks++; if (bus.match_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b need 0", bus.match_valid); end
    step();  // first push lands
    checks++; if (bus.match_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: match_valid got %b need 1", bus.match_valid); end
    checks++; if (bus.match_offset !== 6'd0) begin errors++; $display("FAIL basic_head_offset: got %0d need 0", bus.match_offset); end
    checks++; if (bus.match_data !== 24'hABCDEF) begin errors++; $display("FAIL basic_head_data: got %h need abcdef", bus.match_data); end
    wait_pulse("basic");
    bus.filter_result_valid = 1'b0;
    repeat (6) step();
    checks++;
    if (got_q.size() - base !== 3) begin
      errors++; $display("FAIL basic_record_count: got %0d need 3", got_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[base+i].off !== exp_off[i] || got_q[base+i].data !== 24'hABCDEF) begin
          errors++;
          $display("FAIL basic_record%0d: got off=%0d data=%h need off=%0d data=abcdef",
                   i, got_q[base+i].off, got_q[base+i].data, exp_off[i]);
        end
      end
    end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d need 1", pulses - p0); end
    checks++; if (bus.match_count !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d need 3", bus.match_count); end
  endtask

  // Twelve set bits against an 8-deep FIFO with the consumer stalled.
  task automatic test_backpressure();
    int base, p0;
    int bits12 [12];
    logic [63:0] bm;
    bits12 = '{1, 3, 7, 10, 15, 20, 31, 32, 40, 47, 55, 63};
    bm = '0;
    for (int i = 0; i < 12; i++) bm[bits12[i]] = 1'b1;
    apply_reset();
    bus.match_ready = 1'b0;
    base = got_q.size();
    p0   = pulses;
    bus.filter_result       = bm;
    bus.filter_result_data  = 24'h00BEEF;
    bus.filter_result_valid = 1'b1;
    repeat (20) step();
    checks++; if (bus.match_count !== 16'd8) begin errors++; $display("FAIL bp_stall_count: got %0d need 8", bus.match_count); end
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL bp_stall_pulse: got %0d need 0", pulses - p0); end
    checks++; if (bus.match_valid !== 1'b1 || bus.match_offset !== 6'd1) begin
      errors++; $display("FAIL bp_stall_head: got valid=%b off=%0d need valid=1 off=1", bus.match_valid, bus.match_offset);
    end
    checks++; if (got_q.size() - base !== 0) begin errors++; $display("FAIL bp_stall_records: got %0d need 0", got_q.size() - base); end
    bus.match_ready = 1'b1;
    wait_pulse("bp");
    bus.filter_result_valid = 1'b0;
    repeat (15) step();
    checks++;
    if (got_q.size() - base !== 12) begin
      errors++; $display("FAIL bp_record_count: got %0d need 12", got_q.size() - base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got_q[base+i].off !== 6'(bits12[i]) || got_q[base+i].data !== 24'h00BEEF) begin
          errors++;
          $display("FAIL bp_record%0d: got off=%0d data=%h need off=%0d data=00beef",
                   i, got_q[base+i].off, got_q[base+i].data, bits12[i]);
        end
      end
    end
    checks++; if (bus.match_count !== 16'd12) begin errors++; $display("FAIL bp_count: got %0d need 12", bus.match_count); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL bp_pulses: got %0d need 1", pulses - p0); end
  endtask

  // Two bitmaps in a row; valid lingers after the first pulse to prove the
  // consumed result is not taken twice.
  task automatic test_back_to_back();
    int base, p0;
    apply_reset();
    base = got_q.size();
    p0   = pulses;
    bus.filter_result       = 64'h20;
    bus.filter_result_data  = 24'h111111;
    bus.filter_result_valid = 1'b1;
    wait_pulse("b2b_first");
    repeat (4) step();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL b2b_linger_pulses: got %0d need 1", pulses - p0); end
    checks++; if (got_q.size() - base !== 1) begin errors++; $display("FAIL b2b_linger_records: got %0d need 1", got_q.size() - base); end
    bus.filter_result_valid = 1'b0;
    step();
    bus.filter_result       = 64'h8000_0000_0000_0000;
    bus.filter_result_data  = 24'h222222;
    bus.filter_result_valid = 1'b1;
    wait_pulse("b2b_second");
    bus.filter_result_valid = 1'b0;
    repeat (5) step();
    checks++;
    if (got_q.size() - base !== 2) begin
      errors++; $display("FAIL b2b_record_count: got %0d need 2", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base].off !== 6'd5 || got_q[base].data !== 24'h111111) begin
        errors++; $display("FAIL b2b_record0: got off=%0d data=%h need off=5 data=111111", got_q[base].off, got_q[base].data);
      end
      checks++;
      if (got_q[base+1].off !== 6'd63 || got_q[base+1].data !== 24'h222222) begin
        errors++; $display("FAIL b2b_record1: got off=%0d data=%h need off=63 data=222222", got_q[base+1].off, got_q[base+1].data);
      end
    end
    checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d need 2", pulses - p0); end
    checks++; if (bus.match_count !== 16'd2) begin errors++; $display("FAIL b2b_count: got %0d need 2", bus.match_count); end
  endtask

  task automatic test_zero_bitmap();
    int base, p0;
    apply_reset();
    base = got_q.size();
    p0   = pulses;
    bus.filter_result       = '0;
    bus.filter_result_data  = 24'h999999;
    bus.filter_result_valid = 1'b1;
    wait_pulse("zero");
    bus.filter_result_valid = 1'b0;
    repeat (4) step();
    checks++; if (got_q.size() - base !== 0) begin errors++; $display("FAIL zero_records: got %0d need 0", got_q.size() - base); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL zero_pulses: got %0d need 1", pulses - p0); end
    checks++; if (bus.match_count !== 16'd0) begin errors++; $display("FAIL zero_count: got %0d need 0", bus.match_count); end
  endtask

  // Filter done while two records are still queued.
  task automatic test_finish();
    int base;
    apply_reset();
    bus.match_ready = 1'b0;
    base = got_q.size();
    bus.filter_result       = 64'h210;  // bits 4 and 9
    bus.filter_result_data  = 24'h0C0FFE;
    bus.filter_result_valid = 1'b1;
    wait_pulse("finish");
    bus.filter_result_valid = 1'b0;
    bus.filter_result_done  = 1'b1;
    repeat (6) step();
    checks++; if (bus.session_done !== 1'b0) begin errors++; $display("FAIL finish_done_queued: got %b need 0", bus.session_done); end
    checks++; if (bus.match_count !== 16'd2) begin errors++; $display("FAIL finish_count: got %0d need 2", bus.match_count); end
    bus.match_ready = 1'b1;
    step();
    checks++; if (bus.session_done !== 1'b0) begin errors++; $display("FAIL finish_done_one_left: got %b need 0", bus.session_done); end
    step();
    checks++; if (bus.session_done !== 1'b1) begin errors++; $display("FAIL finish_done_drained: got %b need 1", bus.session_done); end
    checks++; if (bus.match_valid !== 1'b0) begin errors++; $display("FAIL finish_valid_drained: got %b need 0", bus.match_valid); end
    bus.filter_result_done = 1'b0;
    step();
    checks++; if (bus.match_count !== 16'd0) begin errors++; $display("FAIL finish_count_clear: got %0d need 0", bus.match_count); end
    checks++; if (bus.session_done !== 1'b0) begin errors++; $display("FAIL finish_done_drop: got %b need 0", bus.session_done); end
    checks++;
    if (got_q.size() - base !== 2) begin
      errors++; $display("FAIL finish_records: got %0d need 2", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base].off !== 6'd4 || got_q[base+1].off !== 6'd9) begin
        errors++; $display("FAIL finish_order: got %0d,%0d need 4,9", got_q[base].off, got_q[base+1].off);
      end
    end
  endtask

  // Reset while three bits are still pending in the working bitmap.
  task automatic test_reset_mid_scan();
    int base, p0;
    apply_reset();
    base = got_q.size();
    p0   = pulses;
    bus.filter_result       = 64'h3F;
    bus.filter_result_data  = 24'h5A5A5A;
    bus.filter_result_valid = 1'b1;
    repeat (5) step();  // LOAD, SCAN, then pushes of offsets 0,1,2
    checks++; if (bus.match_count !== 16'd3) begin errors++; $display("FAIL midscan_pre_count: got %0d need 3", bus.match_count); end
    areset_n = 1'b0;
    bus.filter_result_valid = 1'b0;
    step();
    checks++; if (bus.match_valid !== 1'b0) begin errors++; $display("FAIL midscan_valid: got %b need 0", bus.match_valid); end
    checks++; if (bus.match_count !== 16'd0) begin errors++; $display("FAIL midscan_count: got %0d need 0", bus.match_count); end
    checks++; if (bus.filter_result_reset !== 1'b0) begin errors++; $display("FAIL midscan_filter_reset: got %b need 0", bus.filter_result_reset); end
    areset_n = 1'b1;
    repeat (10) step();
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL midscan_pulses: got %0d need 0", pulses - p0); end
    checks++; if (got_q.size() - base !== 2) begin errors++; $display("FAIL midscan_records: got %0d need 2", got_q.size() - base); end
    base = got_q.size();
    bus.filter_result       = 64'h80;
    bus.filter_result_data  = 24'h777777;
    bus.filter_result_valid = 1'b1;
    wait_pulse("midscan_after");
    bus.filter_result_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (got_q.size() - base !== 1) begin
      errors++; $display("FAIL midscan_after_records: got %0d need 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base].off !== 6'd7 || got_q[base].data !== 24'h777777) begin
        errors++; $display("FAIL midscan_after_record: got off=%0d data=%h need off=7 data=777777", got_q[base].off, got_q[base].data);
      end
    end
  endtask

  // Five matches into a 2-bit counter: 1,2,3 then held at all-ones.
  task automatic test_saturation();
    int r0, p0;
    bit seen;
    r0 = recs2;
    p0 = pulses2;
    bus2.filter_result       = 64'h1F0;  // bits 4..8
    bus2.filter_result_data  = 24'h5A7000;
    bus2.filter_result_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (bus2.filter_result_reset) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL sat_pulse_timeout: filter_result_reset not seen, need one within 60 cycles"); end
    bus2.filter_result_valid = 1'b0;
    repeat (5) step();
    checks++; if (bus2.match_count !== 2'b11) begin errors++; $display("FAIL sat_count: got %0d need 3", bus2.match_count); end
    checks++; if (recs2 - r0 !== 5) begin errors++; $display("FAIL sat_records: got %0d need 5", recs2 - r0); end
    checks++; if (pulses2 - p0 !== 1) begin errors++; $display("FAIL sat_pulses: got %0d need 1", pulses2 - p0); end
  endtask

  initial begin
    areset_n                  = 1'b0;
    bus.filter_result         = '0;
    bus.filter_result_data    = '0;
    bus.filter_result_valid   = 1'b0;
    bus.filter_result_done    = 1'b0;
    bus.match_ready           = 1'b1;
    bus2.filter_result        = '0;
    bus2.filter_result_data   = '0;
    bus2.filter_result_valid  = 1'b0;
    bus2.filter_result_done   = 1'b0;
    bus2.match_ready          = 1'b1;

    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_zero_bitmap();
    test_finish();
    test_reset_mid_scan();
    test_saturation();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
